// File: rtl/pcie_bench_app.sv
// PCIe benchmark responder: streams a counting FPGA->CPU chunk, then times how long
// the host takes to answer via register writes or CPU->FPGA queue beats.
module pcie_bench_app #(
    parameter int F2C_QW      = 16,
    parameter int C2F_QW      = 16,
    parameter int TIMER_CHAN  = 0,
    parameter int SINGLE_CHAN = 1
) (
    input  logic        clk_in,
    input  logic        rstn,
    input  logic [6:0]  cpuChan_in,
    input  logic [31:0] cpuWrData_in,
    input  logic        cpuWrValid_in,
    input  logic        cpuRdValid_in,
    output logic [31:0] cpuRdData_out,
    output logic        cpuRdValid_out,
    output logic [63:0] f2cData_out,
    output logic        f2cValid_out,
    input  logic        f2cReady_in,
    input  logic [63:0] c2fData_in,
    input  logic        c2fValid_in,
    output logic        c2fReady_out,
    output logic [1:0]  state_dbg
);

    localparam int RESP_MAX_I = 2 * C2F_QW;
    localparam int RESP_W     = $clog2(RESP_MAX_I + 1);
    localparam int BEAT_W     = $clog2(C2F_QW + 1);

    localparam logic [RESP_W-1:0] RESP_MAX = RESP_W'(RESP_MAX_I);
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(C2F_QW);
    localparam logic [31:0]       LAST_IDX = 32'(F2C_QW - 1);
    localparam logic [6:0]        TCH      = 7'(TIMER_CHAN);
    localparam logic [6:0]        SCH      = 7'(SINGLE_CHAN);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [31:0]       timer;
    logic [31:0]       idx;
    logic [RESP_W-1:0] resp_cnt;
    logic [BEAT_W-1:0] beat_cnt;
    logic              flag;

    logic              active;
    logic              start;
    logic              resp_wr;
    logic              resp_inc;
    logic              beat_inc;
    logic              f2c_acc;
    logic              complete;
    logic [RESP_W-1:0] resp_next;
    logic [BEAT_W-1:0] beat_next;
    logic [31:0]       rd_mux;

    // Handshakes: a qword moves on f2c when f2cValid_out && f2cReady_in at a rising
    // edge; data and valid stay put while ready is low. The c2f side is always ready,
    // so every cycle with c2fValid_in high is one beat.
    assign c2fReady_out = 1'b1;
    assign f2cValid_out = (state == SEND);
    assign f2cData_out  = (state == SEND) ? {idx, ~idx} : 64'd0;
    assign state_dbg    = state;

    always_comb begin
        active    = (state == SEND) || (state == WAIT_RSP);
        start     = cpuWrValid_in && (cpuChan_in == TCH) && (cpuWrData_in == 32'd0);
        resp_wr   = cpuWrValid_in && (cpuChan_in == TCH) && (cpuWrData_in != 32'd0);
        resp_inc  = active && resp_wr && (resp_cnt != RESP_MAX);
        beat_inc  = active && c2fValid_in && (beat_cnt != BEAT_MAX);
        resp_next = resp_cnt + RESP_W'(resp_inc);
        beat_next = beat_cnt + BEAT_W'(beat_inc);
        // Completion includes the events arriving this cycle.
        complete  = flag ? (resp_next != '0)
                         : ((resp_next == RESP_MAX) || (beat_next == BEAT_MAX));
        f2c_acc   = (state == SEND) && f2cReady_in;

        state_next = state;
        if (start) begin
            state_next = SEND;
        end else begin
            case (state)
                SEND: begin
                    if (f2c_acc && (idx == LAST_IDX)) begin
                        state_next = complete ? DONE : WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (complete) begin
                        state_next = DONE;
                    end
                end
                default: ;
            endcase
        end

        rd_mux = 32'd0;
        if (cpuChan_in == TCH) begin
            rd_mux = timer;
        end else if (cpuChan_in == SCH) begin
            rd_mux = {31'd0, flag};
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rstn) begin
            state          <= IDLE;
            timer          <= 32'd0;
            idx            <= 32'd0;
            resp_cnt       <= '0;
            beat_cnt       <= '0;
            flag           <= 1'b0;
            cpuRdValid_out <= 1'b0;
            cpuRdData_out  <= 32'd0;
        end else begin
            state          <= state_next;
            cpuRdValid_out <= cpuRdValid_in;
            cpuRdData_out  <= cpuRdValid_in ? rd_mux : 32'd0;

            if (cpuWrValid_in && (cpuChan_in == SCH)) begin
                flag <= cpuWrData_in[0];
            end

            if (start) begin
                timer    <= 32'd0;
                idx      <= 32'd0;
                resp_cnt <= '0;
                beat_cnt <= '0;
            end else begin
                if (active && (timer != 32'hFFFF_FFFF)) begin
                    timer <= timer + 32'd1;
                end
                if (f2c_acc) begin
                    idx <= idx + 32'd1;
                end
                resp_cnt <= resp_next;
                beat_cnt <= beat_next;
            end
        end
    end

endmodule

// File: tb/tb_pcie_bench_app.sv
// Bench for pcie_bench_app: register vector table, directed run scenarios and
// randomized runs checked against a count-based model of a benchmark run.
module tb_pcie_bench_app;

    localparam int F2C_QW      = 16;
    localparam int C2F_QW      = 16;
    localparam logic [6:0] TCH = 7'd0;
    localparam logic [6:0] SCH = 7'd1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic        clk_in = 1'b0;
    logic        rstn;
    logic [6:0]  cpuChan_in;
    logic [31:0] cpuWrData_in;
    logic        cpuWrValid_in;
    logic        cpuRdValid_in;
    logic [31:0] cpuRdData_out;
    logic        cpuRdValid_out;
    logic [63:0] f2cData_out;
    logic        f2cValid_out;
    logic        f2cReady_in;
    logic [63:0] c2fData_in;
    logic        c2fValid_in;
    logic        c2fReady_out;
    logic [1:0]  state_dbg;

    int n_pass  = 0;
    int n_total = 0;
    int run_cycles;

    pcie_bench_app #(
        .F2C_QW(F2C_QW), .C2F_QW(C2F_QW), .TIMER_CHAN(0), .SINGLE_CHAN(1)
    ) dut (
        .clk_in(clk_in), .rstn(rstn),
        .cpuChan_in(cpuChan_in), .cpuWrData_in(cpuWrData_in),
        .cpuWrValid_in(cpuWrValid_in), .cpuRdValid_in(cpuRdValid_in),
        .cpuRdData_out(cpuRdData_out), .cpuRdValid_out(cpuRdValid_out),
        .f2cData_out(f2cData_out), .f2cValid_out(f2cValid_out), .f2cReady_in(f2cReady_in),
        .c2fData_in(c2fData_in), .c2fValid_in(c2fValid_in), .c2fReady_out(c2fReady_out),
        .state_dbg(state_dbg)
    );

    // clock / watchdog
    always #5 clk_in = ~clk_in;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // driver tasks
    task automatic wr(input logic [6:0] ch, input logic [31:0] d);
        cpuWrValid_in = 1'b1;
        cpuChan_in    = ch;
        cpuWrData_in  = d;
        tick();
        cpuWrValid_in = 1'b0;
    endtask

    task automatic rd(input logic [6:0] ch, output logic [31:0] d);
        cpuRdValid_in = 1'b1;
        cpuChan_in    = ch;
        tick();
        check("rd_valid", 64'(cpuRdValid_out), 64'(1));
        d = cpuRdData_out;
        cpuRdValid_in = 1'b0;
    endtask

    task automatic start_run();
        wr(TCH, 32'd0);
        check("start_state", 64'(state_dbg), 64'(S_SEND));
    endtask

    // One run from the first SEND cycle. Model: qword n is {n,~n}; the run completes
    // once all F2C_QW qwords are accepted and beats_needed beats have arrived;
    // every cycle up to and including completion is timed.
    task automatic run_chunk(input int ready_pct, input int beat_pct, input bit hold,
                             input int beats_needed);
        logic [63:0] exp_q[$];
        int acc, beats, cyc;
        bit finished;
        logic [1:0] exp_state;
        for (int i = 0; i < F2C_QW; i++) exp_q.push_back({i[31:0], ~i[31:0]});
        acc = 0; beats = 0; cyc = 0; finished = 0;
        while (!finished && cyc < 4000) begin
            f2cReady_in = (int'($urandom_range(0, 99)) < ready_pct);
            c2fValid_in = (beats < beats_needed) && !(hold && acc < F2C_QW)
                          && (int'($urandom_range(0, 99)) < beat_pct);
            c2fData_in  = {$urandom, $urandom};
            check("f2c_valid", 64'(f2cValid_out), 64'(acc < F2C_QW));
            if (acc < F2C_QW) begin
                check("f2c_data", f2cData_out, exp_q[0]);
                if (f2cReady_in) begin
                    void'(exp_q.pop_front());
                    acc++;
                end
            end
            if (c2fValid_in) beats++;
            finished = (acc == F2C_QW) && (beats >= beats_needed);
            tick();
            cyc++;
            if (finished && beats_needed > 0) exp_state = S_DONE;
            else if (acc < F2C_QW)            exp_state = S_SEND;
            else                              exp_state = S_WAIT;
            check("run_state", 64'(state_dbg), 64'(exp_state));
        end
        if (!finished) check("run_budget", 64'(0), 64'(1));
        f2cReady_in = 1'b0;
        c2fValid_in = 1'b0;
        run_cycles  = cyc;
    endtask

    typedef struct {
        logic        wr;
        logic [6:0]  chan;
        logic [31:0] data;
        logic        rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] d;
        logic [31:0] d2;

        vecs[0]  = '{1'b1, SCH,   32'd1,         1'b1, 32'd0};
        vecs[1]  = '{1'b0, SCH,   32'd0,         1'b1, 32'd1};
        vecs[2]  = '{1'b1, SCH,   32'hFFFF_FFFE, 1'b1, 32'd1};
        vecs[3]  = '{1'b0, SCH,   32'd0,         1'b1, 32'd0};
        vecs[4]  = '{1'b0, 7'd5,  32'd0,         1'b1, 32'd0};
        vecs[5]  = '{1'b1, 7'd127,32'd123,       1'b1, 32'd0};
        vecs[6]  = '{1'b0, TCH,   32'd0,         1'b1, 32'd0};
        vecs[7]  = '{1'b1, TCH,   32'd7,         1'b1, 32'd0};
        vecs[8]  = '{1'b1, SCH,   32'd3,         1'b0, 32'd0};
        vecs[9]  = '{1'b0, SCH,   32'd0,         1'b1, 32'd1};
        vecs[10] = '{1'b1, SCH,   32'd2,         1'b0, 32'd0};
        vecs[11] = '{1'b0, SCH,   32'd0,         1'b1, 32'd0};

        rstn = 1'b0; cpuChan_in = '0; cpuWrData_in = '0; cpuWrValid_in = 1'b0;
        cpuRdValid_in = 1'b0; f2cReady_in = 1'b0; c2fData_in = '0; c2fValid_in = 1'b0;
        tick(); tick();
        check("rst_state", 64'(state_dbg), 64'(S_IDLE));
        check("rst_f2c_valid", 64'(f2cValid_out), 64'(0));
        check("rst_f2c_data", f2cData_out, 64'(0));
        check("rst_rd_valid", 64'(cpuRdValid_out), 64'(0));
        check("rst_rd_data", 64'(cpuRdData_out), 64'(0));
        rstn = 1'b1;
        tick();
        check("c2f_ready", 64'(c2fReady_out), 64'(1));

        // register vector table, all in IDLE
        for (int i = 0; i < 12; i++) begin
            cpuWrValid_in = vecs[i].wr;
            cpuChan_in    = vecs[i].chan;
            cpuWrData_in  = vecs[i].data;
            cpuRdValid_in = vecs[i].rd;
            tick();
            cpuWrValid_in = 1'b0;
            cpuRdValid_in = 1'b0;
            check($sformatf("vec%0d_rd_valid", i), 64'(cpuRdValid_out), 64'(vecs[i].rd));
            if (vecs[i].rd) check($sformatf("vec%0d_rd_data", i), 64'(cpuRdData_out), 64'(vecs[i].exp));
            check($sformatf("vec%0d_state", i), 64'(state_dbg), 64'(S_IDLE));
        end

        // full-rate chunk, 16 beats right after it
        start_run();
        run_chunk(100, 100, 1'b1, C2F_QW);
        rd(TCH, d);
        check("timer_queue_mode", 64'(d), 64'(32));

        // single-response mode
        wr(SCH, 32'd1);
        start_run();
        run_chunk(100, 0, 1'b0, 0);
        wr(TCH, 32'hDEAD_F00D);
        check("single_done", 64'(state_dbg), 64'(S_DONE));
        wr(TCH, 32'hDEAD_F00D);
        check("single_after", 64'(state_dbg), 64'(S_DONE));
        rd(TCH, d);
        rd(TCH, d2);
        check("single_timer1", 64'(d), 64'(17));
        check("single_timer2", 64'(d2), 64'(17));

        // 2*C2F_QW response writes
        wr(SCH, 32'd0);
        start_run();
        run_chunk(100, 0, 1'b0, 0);
        for (int i = 1; i <= 2 * C2F_QW; i++) begin
            wr(TCH, 32'hDEAD_F00D);
            check($sformatf("resp_wr%0d_state", i), 64'(state_dbg),
                  64'((i == 2 * C2F_QW) ? S_DONE : S_WAIT));
        end
        rd(TCH, d);
        check("resp_timer", 64'(d), 64'(48));

        // beat and response write in the same cycle both count
        start_run();
        run_chunk(100, 0, 1'b0, 0);
        for (int i = 0; i < 15; i++) begin
            c2fValid_in = 1'b1;
            wr(TCH, 32'h1234_5678);
        end
        c2fValid_in = 1'b0;
        for (int i = 16; i <= 2 * C2F_QW; i++) begin
            wr(TCH, 32'h1234_5678);
            check($sformatf("mixed%0d_state", i), 64'(state_dbg),
                  64'((i == 2 * C2F_QW) ? S_DONE : S_WAIT));
        end
        rd(TCH, d);
        check("mixed_timer", 64'(d), 64'(48));

        // restart during WAIT_RSP after 10 beats
        start_run();
        run_chunk(100, 0, 1'b0, 0);
        c2fValid_in = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        c2fValid_in = 1'b0;
        check("pre_restart_state", 64'(state_dbg), 64'(S_WAIT));
        start_run();
        run_chunk(100, 100, 1'b1, C2F_QW);
        rd(TCH, d);
        check("restart_timer", 64'(d), 64'(32));

        // randomized runs, stalls and overlapping beats
        for (int r = 0; r < 6; r++) begin
            start_run();
            run_chunk(50, (r < 3) ? 30 : 100, (r == 5), C2F_QW);
            rd(TCH, d);
            check($sformatf("rand%0d_timer", r), 64'(d), 64'(run_cycles));
        end

        // reset in SEND at qword 5
        wr(SCH, 32'd1);
        start_run();
        f2cReady_in = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        f2cReady_in = 1'b0;
        check("pre_rst_data", f2cData_out, {32'd5, ~32'd5});
        rstn = 1'b0;
        cpuRdValid_in = 1'b1;
        cpuChan_in = TCH;
        tick();
        rstn = 1'b1;
        cpuRdValid_in = 1'b0;
        check("mid_rst_state", 64'(state_dbg), 64'(S_IDLE));
        check("mid_rst_f2c_valid", 64'(f2cValid_out), 64'(0));
        check("mid_rst_f2c_data", f2cData_out, 64'(0));
        check("mid_rst_rd_valid", 64'(cpuRdValid_out), 64'(0));
        check("mid_rst_rd_data", 64'(cpuRdData_out), 64'(0));
        f2cReady_in = 1'b1;
        tick();
        check("post_rst_f2c_valid", 64'(f2cValid_out), 64'(0));
        f2cReady_in = 1'b0;
        rd(TCH, d);
        check("post_rst_timer", 64'(d), 64'(0));
        rd(SCH, d);
        check("post_rst_flag", 64'(d), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pcie_bench_app.md
PCIE_BENCH_APP -- requirements
Module: pcie_bench_app

Interface
REQ-001 Parameter F2C_QW, default 16: qwords per FPGA->CPU chunk emitted per benchmark run.
REQ-002 Parameter C2F_QW, default 16: qwords per CPU->FPGA chunk that completes a run in queue mode.
REQ-003 Parameter TIMER_CHAN, default 0: register channel for the benchmark timer.
REQ-004 Parameter SINGLE_CHAN, default 1: register channel for the single-reg-response flag.
REQ-005 Port clk_in  in  1  sole clock; all logic rising-edge.
REQ-006 Port rstn  in  1  reset, synchronous, active-low.
REQ-007 Port cpuChan_in  in  7  register channel of the current write/read request.
REQ-008 Port cpuWrData_in  in  32  register write data.
REQ-009 Port cpuWrValid_in  in  1  one-cycle register write strobe.
REQ-010 Port cpuRdValid_in  in  1  one-cycle register read strobe.
REQ-011 Port cpuRdData_out  out  32  read data.
REQ-012 Port cpuRdValid_out  out  1  read data valid strobe.
REQ-013 Port f2cData_out  out  64  FPGA->CPU chunk qword.
REQ-014 Port f2cValid_out  out  1  f2cData_out valid.
REQ-015 Port f2cReady_in  in  1  downstream accepts qword when valid&ready.
REQ-016 Port c2fData_in  in  64  CPU->FPGA chunk qword.
REQ-017 Port c2fValid_in  in  1  c2fData_in valid.
REQ-018 Port c2fReady_out  out  1  block accepts qword; SHALL be constant 1 after reset.

Function
REQ-019 FSM states SHALL be IDLE, SEND, WAIT_RSP, DONE.
REQ-020 Start event: cpuWrValid_in with cpuChan_in=TIMER_CHAN and cpuWrData_in=0; in any state SHALL next-cycle enter SEND, clear timer, qword index, and both response counters (restart aborts an in-flight run).
REQ-021 Response write: cpuWrValid_in, cpuChan_in=TIMER_CHAN, data nonzero; counted only in SEND/WAIT_RSP, ignored in IDLE/DONE.
REQ-022 Queue beat: c2fValid_in high; counted only in SEND/WAIT_RSP, silently discarded otherwise.
REQ-023 SEND: f2cValid_out=1; qword i SHALL be {i[31:0], ~i[31:0]}; index advances only on valid&ready; data held stable while ready low.
REQ-024 SEND->WAIT_RSP on acceptance of qword F2C_QW-1; SEND->DONE directly if completion already met at that edge.
REQ-025 Completion: single flag=1 -> 1 response write; flag=0 -> 2*C2F_QW response writes or C2F_QW queue beats, whichever first.
REQ-026 WAIT_RSP->DONE on the cycle the completing event is counted.
REQ-027 Timer 32-bit, increments each cycle in SEND and WAIT_RSP, including the completing cycle; frozen in IDLE/DONE; saturates at 0xFFFFFFFF.
REQ-028 Counters SHALL saturate at their completion thresholds; excess events ignored.
REQ-029 Write to SINGLE_CHAN sets flag = cpuWrData_in[0]; takes effect immediately, including mid-run.
REQ-030 Read: cpuRdValid_out and cpuRdData_out one cycle after cpuRdValid_in; TIMER_CHAN -> timer, SINGLE_CHAN -> {31'b0, flag}, other channels -> 0.
REQ-031 Simultaneous register write and read in one cycle both serviced; the read returns the pre-write value.
REQ-032 Simultaneous queue beat and response write in one cycle both count.

Reset
REQ-033 rstn low at a clock edge SHALL force IDLE, timer=0, flag=0, counters=0, index=0, f2cValid_out=0, cpuRdValid_out=0, cpuRdData_out=0, f2cData_out=0; c2fReady_out=1 from first cycle after reset; reset mid-run abandons the run without emitting further qwords.

Verification
REQ-034 Start, f2cReady_in=1, 16 queue beats immediately after last F2C qword -> 16 qwords {0,FFFFFFFF}..{F,FFFFFFF0}, DONE, timer read = 32.
REQ-035 flag=1, start, one write DEADF00D after chunk -> DONE same cycle; subsequent writes ignored; timer unchanged across two reads.
REQ-036 flag=0, start, 32 writes DEADF00D -> DONE only after 32nd; 31 writes leave state WAIT_RSP.
REQ-037 f2cReady_in toggled 50% -> qword sequence unchanged, no duplicates/drops, data stable while stalled.
REQ-038 Restart during WAIT_RSP after 10 beats -> new chunk from index 0, timer restarts at 0, 16 fresh beats needed.
REQ-039 rstn low during SEND at qword 5 -> all outputs at reset values next cycle; timer read returns 0.
